// File: rtl/fifo_rd_stream_if.sv
// Purpose: bundles the FIFO read port, the flush control and the valid/ready
//          output stream of fifo_rd_stream into one interface.
// Signals:
//   flush        synchronous clear request (environment -> adapter)
//   fifo_empty   FIFO empty flag            (FIFO -> adapter)
//   fifo_rd_en   FIFO read strobe           (adapter -> FIFO)
//   fifo_rd_data FIFO read data, 1-cycle latency (FIFO -> adapter)
//   m_valid      output word valid          (adapter -> consumer)
//   m_ready      consumer ready             (consumer -> adapter)
//   m_data       output word                (adapter -> consumer)
//   level        buffered word count 0..2   (adapter -> environment)
// Modports: master = adapter side, slave = FIFO/consumer side.
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 4
);
  logic                  flush;
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic [1:0]            level;

  modport master (
    input  flush, fifo_empty, fifo_rd_data, m_ready,
    output fifo_rd_en, m_valid, m_data, level
  );

  modport slave (
    output flush, fifo_empty, fifo_rd_data, m_ready,
    input  fifo_rd_en, m_valid, m_data, level
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Purpose: read-side adapter between an async FIFO read port and a
//          valid/ready consumer. Issues reads against fifo_empty, absorbs the
//          1-cycle RAM read latency in a 2-entry circular buffer and presents
//          registered m_valid/m_data at up to one word per cycle.
// Ports:
//   rd_clk  FIFO read clock
//   rd_rst  synchronous, active-high reset
//   bus     fifo_rd_stream_if.master (FIFO read port, flush, output stream,
//           level)
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 4
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  fifo_rd_stream_if.master bus
);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [DATA_WIDTH-1:0] mem_d [2];
  logic                  head_q, head_d;
  logic                  tail_q, tail_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  inflight_q, inflight_d;
  logic                  flush_q, flush_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;

  logic       pop;
  logic       push;
  logic [1:0] occ;
  logic       rd_en;

  // Occupancy seen by a read issued now: stored words plus the word already
  // in flight, minus the word leaving this cycle. Never exceeds 2.
  always_comb begin
    pop   = (cnt_q != '0) & bus.m_ready;
    push  = inflight_q & ~flush_q;
    occ   = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    rd_en = ~rd_rst & ~bus.flush & ~bus.fifo_empty & (occ < 2'd2);
  end

  always_comb begin
    mem_d      = mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    cnt_d      = cnt_q;
    inflight_d = rd_en;
    flush_d    = 1'b0;
    if (bus.flush) begin
      head_d     = '0;
      tail_d     = '0;
      cnt_d      = '0;
      inflight_d = 1'b0;
      flush_d    = 1'b1;
    end else begin
      if (push) begin
        mem_d[tail_q] = bus.fifo_rd_data;
        tail_d        = ~tail_q;
      end
      if (pop) begin
        head_d = ~head_q;
      end
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
    // Outputs are registered from next-state values so they stay aligned
    // with cnt_q/head_q without an extra cycle of latency.
    m_valid_d = (cnt_d != '0);
    m_data_d  = mem_d[head_d];
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      flush_q    <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
    end else begin
      mem_q      <= mem_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      flush_q    <= flush_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_data     = m_data_q;
  assign bus.level      = cnt_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Testbench for fifo_rd_stream (DATA_WIDTH=8): a vector table for reset and
// the single-word empty boundary, plus scoreboard-driven sequences for
// streaming, backpressure, flush and a long random run.
module tb_fifo_rd_stream;
  localparam int DW = 8;

  logic rd_clk = 1'b0;
  logic rd_rst;
  always #5 rd_clk = ~rd_clk;

  fifo_rd_stream_if #(.DATA_WIDTH(DW)) bus ();

  fifo_rd_stream #(.DATA_WIDTH(DW)) dut (
    .rd_clk (rd_clk),
    .rd_rst (rd_rst),
    .bus    (bus)
  );

  typedef struct {
    logic          rst;
    logic          fl;
    logic          empty;
    logic          rdy;
    logic [DW-1:0] din;
    logic          x_en;
    logic          x_valid;
    logic [DW-1:0] x_data;
    logic [1:0]    x_lvl;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] model_q [$];
  logic [DW-1:0] exp_q   [$];
  logic          pend_v;
  logic [DW-1:0] pend_d;
  int            cyc;
  bit            hold_prev;
  logic [DW-1:0] hold_data;
  bit            popped;
  bit            issued;
  logic [DW-1:0] pop_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // One clock cycle: drive inputs at negedge, sample outputs 1 time unit later.
  task automatic drive_cycle(input bit rst, input bit fl, input bit rdy, input bit stall);
    @(negedge rd_clk);
    cyc++;
    rd_rst           = rst;
    bus.flush        = fl;
    bus.m_ready      = rdy;
    bus.fifo_empty   = (model_q.size() == 0) | stall;
    bus.fifo_rd_data = pend_v ? pend_d : DW'($urandom);
    pend_v           = 1'b0;
    #1;
    popped = 1'b0;
    issued = 1'b0;
    check("rd_en_while_empty", 32'(bus.fifo_rd_en & bus.fifo_empty), 32'd0);
    check("level_le_2", 32'(bus.level <= 2'd2), 32'd1);
    if (rst || fl) check("rd_en_in_rst_flush", 32'(bus.fifo_rd_en), 32'd0);
    if (hold_prev) begin
      check("hold_valid", 32'(bus.m_valid), 32'd1);
      check("hold_data", 32'(bus.m_data), 32'(hold_data));
    end
    if (!rst && bus.m_valid && bus.m_ready) begin
      popped   = 1'b1;
      pop_data = bus.m_data;
      check("pop_has_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("order", 32'(bus.m_data), 32'(exp_q.pop_front()));
    end
    if (bus.fifo_rd_en && model_q.size() != 0) begin
      issued = 1'b1;
      pend_v = 1'b1;
      pend_d = model_q.pop_front();
      exp_q.push_back(pend_d);
    end
    if (rst || fl) exp_q.delete();
    hold_prev = !rst && !fl && bus.m_valid && !bus.m_ready;
    hold_data = bus.m_data;
  endtask

  task automatic do_reset();
    model_q.delete();
    exp_q.delete();
    pend_v    = 1'b0;
    hold_prev = 1'b0;
    repeat (3) drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(input int first, input int count);
    for (int i = 0; i < count; i++) model_q.push_back(DW'(first + i));
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    @(negedge rd_clk);
    rd_rst           = v.rst;
    bus.flush        = v.fl;
    bus.fifo_empty   = v.empty;
    bus.m_ready      = v.rdy;
    bus.fifo_rd_data = v.din;
    #1;
    check($sformatf("vec%0d_rd_en", idx), 32'(bus.fifo_rd_en), 32'(v.x_en));
    check($sformatf("vec%0d_m_valid", idx), 32'(bus.m_valid), 32'(v.x_valid));
    check($sformatf("vec%0d_m_data", idx), 32'(bus.m_data), 32'(v.x_data));
    check($sformatf("vec%0d_level", idx), 32'(bus.level), 32'(v.x_lvl));
  endtask

  initial begin
    vec_t vecs [9];
    int first_en, first_v, first_pop, last_pop, npop;
    bit saw;
    logic [DW-1:0] next_val;

    // rst fl empty rdy din | rd_en valid data level
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 2'd0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 2'd0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 2'd0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 2'd0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 8'h00, 2'd0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 2'd0};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b1, 8'hA5, 2'd1};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 8'h00, 2'd0};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 8'h00, 2'd0};

    rd_rst           = 1'b1;
    bus.flush        = 1'b0;
    bus.fifo_empty   = 1'b1;
    bus.m_ready      = 1'b0;
    bus.fifo_rd_data = '0;
    cyc              = 0;
    pend_v           = 1'b0;
    hold_prev        = 1'b0;

    // Reset and single-word empty boundary
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) apply_vec(i, vecs[i]);

    // Streaming 01..10 with m_ready=1
    do_reset();
    load(1, 16);
    first_en = -1; first_v = -1; first_pop = -1; last_pop = -1; npop = 0;
    for (int k = 0; k < 40; k++) begin
      drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
      if (issued && first_en < 0) first_en = cyc;
      if (bus.m_valid && first_v < 0) first_v = cyc;
      if (popped) begin
        if (npop == 0) first_pop = cyc;
        last_pop = cyc;
        npop++;
      end
    end
    check("stream_latency", 32'(first_v - first_en), 32'd2);
    check("stream_count", 32'(npop), 32'd16);
    check("stream_no_bubbles", 32'(last_pop - first_pop), 32'd15);

    // Backpressure once 8'h03 is presented
    do_reset();
    load(1, 16);
    saw = 1'b0;
    for (int k = 0; k < 20 && !saw; k++) begin
      drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
      if (popped && pop_data == 8'h02) saw = 1'b1;
    end
    check("bp_reached_02", 32'(saw), 32'd1);
    repeat (4) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("bp_valid", 32'(bus.m_valid), 32'd1);
    check("bp_data", 32'(bus.m_data), 32'h03);
    check("bp_level", 32'(bus.level), 32'd2);
    check("bp_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    for (int j = 0; j < 3; j++) begin
      drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
      check($sformatf("bp_release%0d_pop", j), 32'(popped), 32'd1);
      check($sformatf("bp_release%0d_data", j), 32'(pop_data), 32'(3 + j));
    end

    // Flush right after a read issued at level 2
    do_reset();
    load(8'h30, 16);
    repeat (4) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("fl_setup_level", 32'(bus.level), 32'd2);
    check("fl_setup_no_rd", 32'(bus.fifo_rd_en), 32'd0);
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("fl_issue_before", 32'(bus.fifo_rd_en), 32'd1);
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("fl_valid_cleared", 32'(bus.m_valid), 32'd0);
    check("fl_level_cleared", 32'(bus.level), 32'd0);
    check("fl_issue_resumes", 32'(bus.fifo_rd_en), 32'd1);
    saw = 1'b0;
    for (int k = 0; k < 10 && !saw; k++) begin
      drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
      if (popped) begin
        saw = 1'b1;
        check("fl_first_after", 32'(pop_data), 32'h33);
      end
    end
    check("fl_output_resumed", 32'(saw), 32'd1);

    // Random m_ready / fifo_empty / occasional flush
    do_reset();
    next_val = 8'h00;
    for (int k = 0; k < 10000; k++) begin
      while (model_q.size() < 3) begin
        model_q.push_back(next_val);
        next_val = next_val + 8'd1;
      end
      drive_cycle(1'b0, ($urandom % 200) == 0, ($urandom % 3) != 0, ($urandom % 4) == 0);
    end
    for (int k = 0; k < 60; k++) begin
      drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
      if (model_q.size() == 0 && exp_q.size() == 0 && !bus.m_valid && !pend_v) break;
    end
    check("rand_drained_no_loss", 32'(exp_q.size()), 32'd0);
    check("rand_final_valid", 32'(bus.m_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
